raw10_unpacker: RTL

Pixel-unpacking stage directly downstream of the CSI-2 packet receiver. Consumes the receiver's 32-bit long-packet payload words and regroups the RAW10 byte stream, five bytes per four pixels, into 4-pixel groups of 10-bit samples. It drops words of any non-RAW10 data type and flags lines that end on a partial group. Output feeds the ISP/framebuffer writer.

---
 rtl/raw10_unpacker.sv | 106 ++++++++++
 1 files changed

// File: rtl/raw10_unpacker.sv
// RAW10 pixel unpacker: regroups 32-bit CSI-2 payload words into 4-pixel groups of 10-bit samples.
// Optional macro RAW10_UNPACKER_RAW8_EN additionally passes RAW8 (8'h2A) words straight through as groups.
module raw10_unpacker (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] image_data,
  input  logic [7:0]  image_data_type,
  input  logic        image_data_enable,
  input  logic        packet_start,
  output logic [39:0] pixel_data,
  output logic        pixel_valid,
  output logic [15:0] pixel_count,
  output logic        residue_error
);

  localparam logic [7:0] DT_RAW10 = 8'h2B;
  localparam logic [7:0] DT_RAW8  = 8'h2A;

  logic [63:0] buf_q;
  logic [63:0] buf_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [63:0] base_buf;
  logic [2:0]  base_cnt;
  logic [63:0] merged;
  logic [3:0]  total;
  logic        accept_raw10;
  logic        accept_raw8;
  logic        emit;
  logic [39:0] group;

  // Five buffered bytes b0..b4 become four pixels; b4 carries the two LSBs of each.
  function automatic logic [39:0] pack_raw10(input logic [39:0] b);
    logic [39:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) begin
      p[10*k +: 10] = {b[8*k +: 8], b[32 + 2*k +: 2]};
    end
    return p;
  endfunction

  function automatic logic [39:0] pack_raw8(input logic [31:0] w);
    logic [39:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) begin
      p[10*k +: 10] = {w[8*k +: 8], 2'b00};
    end
    return p;
  endfunction

  // packet_start empties the buffer before a same-cycle word is appended,
  // so that word becomes bytes 0..3 of the new packet.
  always_comb begin
    accept_raw10 = image_data_enable && (image_data_type == DT_RAW10);
`ifdef RAW10_UNPACKER_RAW8_EN
    accept_raw8  = image_data_enable && (image_data_type == DT_RAW8);
`else
    accept_raw8  = 1'b0;
`endif
    base_buf = packet_start ? 64'd0 : buf_q;
    base_cnt = packet_start ? 3'd0 : cnt_q;
    merged   = base_buf | ({32'd0, image_data} << {base_cnt, 3'b000});
    total    = {1'b0, base_cnt} + 4'd4;

    buf_d = base_buf;
    cnt_d = base_cnt;
    emit  = 1'b0;
    group = pack_raw10(merged[39:0]);

    if (accept_raw10) begin
      if (total >= 4'd5) begin
        emit  = 1'b1;
        buf_d = merged >> 40;
        cnt_d = 3'(total - 4'd5);
      end else begin
        buf_d = merged;
        cnt_d = total[2:0];
      end
    end else if (accept_raw8) begin
      emit  = 1'b1;
      group = pack_raw8(image_data);
    end
  end

  // pixel_data is only loaded on an emitting cycle and otherwise holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_q         <= '0;
      cnt_q         <= '0;
      pixel_data    <= '0;
      pixel_valid   <= 1'b0;
      pixel_count   <= '0;
      residue_error <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      pixel_valid   <= emit;
      if (emit) begin
        pixel_data <= group;
      end
      pixel_count   <= (packet_start ? 16'd0 : pixel_count) + (emit ? 16'd4 : 16'd0);
      residue_error <= packet_start && (cnt_q != 3'd0);
    end
  end

endmodule
